seven_seg_display_driver: RTL



---
 rtl/display_pkg.sv | 28 ++
 rtl/hex_to_seg.sv | 16 +
 rtl/seven_seg_display_driver.sv | 113 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and glyph constants for the seven-segment display driver.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_e;

  typedef struct packed {
    logic        ovf;
    logic [15:0] digits;
  } disp_t;

  localparam int BCD_STEPS = 16;

  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_to_seg.sv
// Nibble to active-low seven-segment glyph.
// Overflow forces the dash glyph regardless of the nibble.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       ovf_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_HEX[nib_i];
    if (ovf_i) seg_o = SEG_DASH;
  end

endmodule

// File: rtl/seven_seg_display_driver.sv
// 4-digit common-anode display driver with hex/decimal capture.
// Decimal mode runs a sequential double-dabble before committing.
module seven_seg_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic [15:0] display_in,
  input  logic        load,
  input  logic        mode_dec,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int CW = $clog2(REFRESH_DIV);

  state_e        state_q;
  disp_t         disp_q;
  logic [15:0]   bin_q;
  logic [19:0]   bcd_q;
  logic [4:0]    step_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic          dp_q;

  logic [19:0]   bcd_d;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  // Double-dabble adjust: nibbles >= 5 get +3 before the shift.
  always_comb begin
    bcd_d = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign nib = disp_q.digits[{idx_q, 2'b00} +: 4];

  hex_to_seg u_dec (
    .nib_i (nib),
    .ovf_i (disp_q.ovf),
    .seg_o (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      disp_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
    end else if (clk_enable) begin
      unique case (state_q)
        IDLE: begin
          if (load && mode_dec) begin
            bin_q   <= display_in;
            bcd_q   <= '0;
            step_q  <= '0;
            state_q <= CONV;
          end else if (load) begin
            disp_q <= '{ovf: 1'b0, digits: display_in};
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= {bcd_d[18:0], bin_q, 1'b0};
          step_q <= step_q + 5'd1;
          if (step_q == 5'(BCD_STEPS - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_q  <= '{ovf: |bcd_q[19:16], digits: bcd_q[15:0]};
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_HEX[0];
      an_q  <= 4'b1110;
      dp_q  <= 1'b1;
    end else if (clk_enable) begin
      if (cnt_q == CW'(REFRESH_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      seg_q <= glyph;
      an_q  <= ~(4'b0001 << idx_q);
      dp_q  <= ~disp_q.ovf;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;
  assign busy = (state_q != IDLE);

endmodule
